// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel circular input buffer for a router port.
// First-word fall-through read, occupancy status and registered credit return.
module vc_fifo #(
  parameter int WIDTH        = 32,
  parameter int ADDR_BITS    = 5,
  parameter int NUM_VC       = 2,
  parameter int VC_BITS      = 1,
  parameter int AFULL_THRESH = (1 << ADDR_BITS) - 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic [VC_BITS-1:0]            write_vc,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          read_en,
  input  logic [VC_BITS-1:0]            read_vc,
  output logic [WIDTH-1:0]              data_out,
  output logic [NUM_VC-1:0]             full,
  output logic [NUM_VC-1:0]             empty,
  output logic [NUM_VC-1:0]             almost_full,
  output logic [NUM_VC*(ADDR_BITS+1)-1:0] ocup,
  output logic                          error,
  output logic                          credit_valid,
  output logic [VC_BITS-1:0]            credit_vc
);

  localparam int PW    = ADDR_BITS + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef logic [PW-1:0] ptr_t;

  ptr_t             wptr [NUM_VC];
  ptr_t             rptr [NUM_VC];
  ptr_t             occ  [NUM_VC];
  logic [WIDTH-1:0] mem  [NUM_VC][DEPTH];

  logic [NUM_VC-1:0] push_hit;
  logic [NUM_VC-1:0] pop_hit;
  logic              wr_bad;
  logic              rd_bad;

  // occupancy per channel; modulo arithmetic absorbs pointer wrap
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      occ[v] = wptr[v] - rptr[v];
    end
  end

  // status flags come from registered pointers only
  always_comb begin
    full        = '0;
    empty       = '0;
    almost_full = '0;
    ocup        = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      empty[v] = (wptr[v] == rptr[v]);
      full[v]  = (wptr[v][ADDR_BITS-1:0] == rptr[v][ADDR_BITS-1:0]) &&
                 (wptr[v][ADDR_BITS] != rptr[v][ADDR_BITS]);
      almost_full[v] = (32'(occ[v]) >= AFULL_THRESH);
      ocup[v*PW +: PW] = occ[v];
    end
  end

  // request qualification; a select with no matching channel stays illegal
  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    wr_bad   = 1'b1;
    rd_bad   = 1'b1;
    data_out = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (write_vc == VC_BITS'(v)) begin
        wr_bad      = full[v];
        push_hit[v] = write_en && !full[v];
      end
      if (read_vc == VC_BITS'(v)) begin
        rd_bad     = empty[v];
        pop_hit[v] = read_en && !empty[v];
        if (!empty[v]) begin
          data_out = mem[v][rptr[v][ADDR_BITS-1:0]];
        end
      end
    end
    error = (write_en && wr_bad) || (read_en && rd_bad);
  end

  // pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wptr[v] <= '0;
        rptr[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (push_hit[v]) wptr[v] <= wptr[v] + 1'b1;
        if (pop_hit[v])  rptr[v] <= rptr[v] + 1'b1;
      end
    end
  end

  // storage write; contents survive reset, pointers define validity
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push_hit[v]) begin
        mem[v][wptr[v][ADDR_BITS-1:0]] <= data_in;
      end
    end
  end

  // one credit pulse per accepted pop; vc held between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_valid <= 1'b0;
      credit_vc    <= '0;
    end else begin
      credit_valid <= |pop_hit;
      if (|pop_hit) credit_vc <= read_vc;
    end
  end

endmodule
